uart_tx_buffered: RTL and testbench

//   UART transmitter: serialises 8-bit bytes as 8N1 frames (start, D0..D7 LSB first, stop) on tx.

---
 rtl/uart_tx_buffered.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - 8N1 UART transmitter with a one-byte holding register
//
// Serialises bytes as start, D0..D7 (LSB first), [parity], stop on tx. A holding
// register behind the shifter lets the next byte start right after the current
// stop bit, with no idle gap between frames.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between D7 and stop (11-bit frames). Undefined builds have no parity logic.
//
// Parameters:
//   CLK_FREQ   system clock frequency, Hz
//   BAUD_RATE  line rate, bit/s; CLK_FREQ/BAUD_RATE must be 2..65535
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, active low
//   data_in     byte to send, taken when data_valid & data_ready at a clk edge
//   data_valid  data_in valid; held by the source until accepted
//   data_ready  holding register can take a byte
//   tx          serial line, idle high
//   busy        frame on the line or byte waiting in the holding register
//   tx_done     one-cycle pulse in the last clock of each stop bit

module uart_tx_buffered #(
  parameter int CLK_FREQ  = 125000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int          BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BIT_LAST = 16'(BIT_TIME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        full_q, full_d;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic take;
  logic bit_end;
  logic direct;

  assign take    = data_valid & ~full_q;
  assign bit_end = (cnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    full_d  = full_q;
    direct  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Counter idles at 0 so a byte accepted in IDLE gets a full start bit.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (take) begin
          direct  = 1'b1;
          shift_d = data_in;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data_in;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (full_q) begin
            shift_d = hold_q;
            full_d  = 1'b0;
            state_d = S_START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^hold_q;
`endif
          end else if (take) begin
            // A byte offered in the very last stop clock bypasses the holding
            // register so it is neither stranded nor delayed.
            direct  = 1'b1;
            shift_d = data_in;
            state_d = S_START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^data_in;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take && !direct) begin
      hold_d = data_in;
      full_d = 1'b1;
    end
  end

  always_comb begin
    tx      = 1'b1;
    tx_done = 1'b0;
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = par_q;
`endif
      S_STOP:  tx_done = bit_end;
      default: tx = 1'b1;
    endcase
  end

  assign busy       = (state_q != S_IDLE) | full_q;
  assign data_ready = ~full_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed self-checking bench for uart_tx_buffered

module tb_uart_tx_buffered;

  localparam int BT = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * BT;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  logic [7:0] data_in2;
  logic       data_valid2;
  logic       data_ready2;
  logic       tx2;
  logic       busy2;
  logic       tx_done2;

  int n_assert;
  int n_fail;

  uart_tx_buffered #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  uart_tx_buffered #(.CLK_FREQ(200), .BAUD_RATE(100)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in2),
    .data_valid (data_valid2),
    .data_ready (data_ready2),
    .tx         (tx2),
    .busy       (busy2),
    .tx_done    (tx_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level k clocks into a frame of byte b with bt clocks per bit.
  function automatic logic exp_bit(input logic [7:0] b, input int k, input int bt);
    int p;
    p = k / bt;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
`ifdef UART_TX_PARITY_EN
    if (p == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Offers n bytes with data_valid held, checking every clock of the n frames.
  // Call just after a falling edge; cycle 0 is the clock after the accepting edge.
  task automatic run_stream(input string name, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n);
    logic [7:0] bq [3];
    int         ptr;
    int         f;
    int         kk;
    logic       take;
    bq  = '{b0, b1, b2};
    ptr = 0;
    chk({name, " busy_pre"}, busy, 1'b0);
    data_in    = bq[0];
    data_valid = 1'b1;
    take       = data_ready;
    for (int k = 0; k < n * FL; k++) begin
      @(negedge clk);
      if (take) ptr++;
      if (ptr < n) begin
        data_valid = 1'b1;
        data_in    = bq[ptr];
      end else begin
        data_valid = 1'b0;
        data_in    = 8'($urandom);
      end
      take = data_valid & data_ready;
      f  = k / FL;
      kk = k % FL;
      chk($sformatf("%s tx c%0d", name, k), tx, exp_bit(bq[f], kk, BT));
      chk($sformatf("%s tx_done c%0d", name, k), tx_done, (kk == FL - 1));
      chk($sformatf("%s busy c%0d", name, k), busy, 1'b1);
      chk($sformatf("%s data_ready c%0d", name, k), data_ready,
          !((kk != 0) && (k < (n - 1) * FL)));
    end
    @(negedge clk);
    data_valid = 1'b0;
    chk({name, " tx_after"}, tx, 1'b1);
    chk({name, " busy_after"}, busy, 1'b0);
    chk({name, " tx_done_after"}, tx_done, 1'b0);
    chk({name, " accepted"}, ptr, n);
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    data_in     = 8'h00;
    data_valid  = 1'b0;
    data_in2    = 8'h00;
    data_valid2 = 1'b0;
    #1;
    chk("reset tx", tx, 1'b1);
    chk("reset data_ready", data_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset tx_done", tx_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte from idle.
    run_stream("b55", 8'h55, 8'h00, 8'h00, 1);

    // Two bytes back to back; second lands in the holding register.
    @(negedge clk);
    run_stream("a5_3c", 8'hA5, 8'h3C, 8'h00, 2);

    // Three bytes with data_valid held throughout.
    @(negedge clk);
    run_stream("x3", 8'h01, 8'h02, 8'h03, 3);

`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    run_stream("par07", 8'h07, 8'h00, 8'h00, 1);
    @(negedge clk);
    run_stream("par03", 8'h03, 8'h00, 8'h00, 1);
`endif

    // Reset in the middle of D3, then a clean frame.
    @(negedge clk);
    data_in    = 8'h55;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    for (int k = 1; k <= 45; k++) @(negedge clk);
    chk("mid tx_before_reset", tx, 1'b0);
    chk("mid busy_before_reset", busy, 1'b1);
    data_in    = 8'hC3;
    data_valid = 1'b1;
    rst_n      = 1'b0;
    #1;
    chk("mid reset tx", tx, 1'b1);
    chk("mid reset busy", busy, 1'b0);
    chk("mid reset data_ready", data_ready, 1'b1);
    data_valid = 1'b0;
    @(negedge clk);
    chk("mid reset held tx", tx, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    run_stream("f0", 8'hF0, 8'h00, 8'h00, 1);

    // Minimum bit time: 2 clocks per bit.
    @(negedge clk);
    chk("bt2 idle tx", tx2, 1'b1);
    data_in2    = 8'h80;
    data_valid2 = 1'b1;
    for (int k = 0; k < NB * 2; k++) begin
      @(negedge clk);
      data_valid2 = 1'b0;
      chk($sformatf("bt2 tx c%0d", k), tx2, exp_bit(8'h80, k, 2));
      chk($sformatf("bt2 tx_done c%0d", k), tx_done2, (k == NB * 2 - 1));
    end
    @(negedge clk);
    chk("bt2 busy_after", busy2, 1'b0);
    chk("bt2 tx_after", tx2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
